// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU opcodes and IEEE-754 single-precision constants
package fpu_pkg;
    typedef enum logic [2:0] {
        FOP_FEQ  = 3'd0,
        FOP_FLT  = 3'd1,
        FOP_FLE  = 3'd2,
        FOP_FMIN = 3'd3,
        FOP_FMAX = 3'd4
    } fop_e;
    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
    localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational NaN/zero/magnitude classification of two singles
//   i_x1, i_x2      operands (IEEE-754 single)
//   o_nan1, o_nan2  operand is a NaN (quiet or signalling)
//   o_bothzero      both operands are +/-0
//   o_mag_lt        |x1| < |x2| (sign ignored)
//   o_mag_eq        |x1| == |x2|
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] i_x1,
    input  logic [31:0] i_x2,
    output logic        o_nan1,
    output logic        o_nan2,
    output logic        o_bothzero,
    output logic        o_mag_lt,
    output logic        o_mag_eq
);
    assign o_nan1     = i_x1[30:23] == FP_EXP_MAX && i_x1[22:0] != '0;
    assign o_nan2     = i_x2[30:23] == FP_EXP_MAX && i_x2[22:0] != '0;
    assign o_bothzero = i_x1[30:0] == '0 && i_x2[30:0] == '0;
    // Sign-magnitude layout makes the unsigned compare of bits 30:0 a magnitude compare
    assign o_mag_lt   = i_x1[30:0] < i_x2[30:0];
    assign o_mag_eq   = i_x1[30:0] == i_x2[30:0];
endmodule

// File: rtl/fcmp_unit.sv
// fcmp_unit: 2-stage pipelined FEQ/FLT/FLE/FMIN/FMAX unit with valid/ready
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake; op, x1, x2, tag accepted on transfer
//   out_valid/out_ready  output handshake; result and out_tag held while stalled
module fcmp_unit
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag
);
    logic             r_s1_valid, r_s2_valid;
    logic [2:0]       r_op;
    logic [TAG_W-1:0] r_tag, r_out_tag;
    logic [31:0]      r_x1, r_x2, r_result;
    logic             r_nan1, r_nan2, r_bothzero, r_mag_lt, r_mag_eq;
    logic             w_nan1, w_nan2, w_bothzero, w_mag_lt, w_mag_eq;
    logic             w_s1_adv, w_any_nan, w_eq, w_lt;
    logic [31:0]      w_min, w_max, w_res;

    fp_classify u_cls (
        .i_x1      (x1),
        .i_x2      (x2),
        .o_nan1    (w_nan1),
        .o_nan2    (w_nan2),
        .o_bothzero(w_bothzero),
        .o_mag_lt  (w_mag_lt),
        .o_mag_eq  (w_mag_eq)
    );

    assign w_s1_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign out_tag   = r_out_tag;

    always_comb begin
        w_any_nan = r_nan1 || r_nan2;
        w_eq      = (r_mag_eq && r_x1[31] == r_x2[31]) || r_bothzero;
        // Differing signs: negative side is smaller unless both are zero
        w_lt      = r_x1[31] != r_x2[31] ? r_x1[31] && !r_bothzero :
                    r_x1[31] ? !r_mag_lt && !r_mag_eq : r_mag_lt;
        w_min     = r_nan1 && r_nan2 ? FP_CANON_NAN : r_nan1 ? r_x2 : r_nan2 ? r_x1 :
                    r_bothzero ? {r_x1[31] | r_x2[31], 31'b0} : w_lt ? r_x1 : r_x2;
        w_max     = r_nan1 && r_nan2 ? FP_CANON_NAN : r_nan1 ? r_x2 : r_nan2 ? r_x1 :
                    r_bothzero ? {r_x1[31] & r_x2[31], 31'b0} : w_lt ? r_x2 : r_x1;
        w_res     = r_op == FOP_FEQ  ? {31'b0, !w_any_nan && w_eq} :
                    r_op == FOP_FLT  ? {31'b0, !w_any_nan && w_lt} :
                    r_op == FOP_FLE  ? {31'b0, !w_any_nan && (w_lt || w_eq)} :
                    r_op == FOP_FMIN ? w_min :
                    r_op == FOP_FMAX ? w_max : 32'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_op       <= '0;
            r_tag      <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_nan1     <= 1'b0;
            r_nan2     <= 1'b0;
            r_bothzero <= 1'b0;
            r_mag_lt   <= 1'b0;
            r_mag_eq   <= 1'b0;
            r_result   <= '0;
            r_out_tag  <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_op       <= op;
                    r_tag      <= tag;
                    r_x1       <= x1;
                    r_x2       <= x2;
                    r_nan1     <= w_nan1;
                    r_nan2     <= w_nan2;
                    r_bothzero <= w_bothzero;
                    r_mag_lt   <= w_mag_lt;
                    r_mag_eq   <= w_mag_eq;
                end
            end
            if (w_s1_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_result  <= w_res;
                    r_out_tag <= r_tag;
                end
            end
        end
    end
endmodule

// File: tb/tb_fcmp_unit.sv
// tb_fcmp_unit: directed and random checks of fcmp_unit against a numeric reference model
module tb_fcmp_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic [4:0]  tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  out_tag;

    int n_checks = 0;
    int n_fails  = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    fcmp_unit #(.TAG_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .x1       (x1),
        .x2       (x2),
        .tag      (tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .out_tag  (out_tag)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic is_nan(input logic [31:0] a);
        return a[30:23] == 8'hFF && a[22:0] != 0;
    endfunction

    // Signed numeric value that orders floats; +0 and -0 both map to 0
    function automatic longint num(input logic [31:0] a);
        longint m;
        m = longint'(a[30:0]);
        return a[31] ? -m : m;
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic   nn, na, nb;
        longint va, vb;
        na = is_nan(a);
        nb = is_nan(b);
        nn = !(na || nb);
        va = num(a);
        vb = num(b);
        case (f)
            3'd0: return {31'b0, nn && va == vb};
            3'd1: return {31'b0, nn && va < vb};
            3'd2: return {31'b0, nn && va <= vb};
            3'd3, 3'd4: begin
                if (na && nb) return 32'h7FC00000;
                if (na) return b;
                if (nb) return a;
                if (va == 0 && vb == 0)
                    return (f == 3'd3 ? (a[31] || b[31]) : (a[31] && b[31])) ? 32'h80000000 : 32'h0;
                if (f == 3'd3) return va <= vb ? a : b;
                return va >= vb ? a : b;
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 6))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return {v[31], 8'hFF, (v[22:0] == 0) ? 23'h1 : v[22:0]};
            3: return {v[31], 31'h7F800000};
            4: return {v[31], 8'h7F + 8'(v[1:0]), 23'h0};
            default: return v;
        endcase
    endfunction

    // Scoreboard: every presented result is compared with the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else begin
            if (out_valid) begin
                if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'h0);
                else begin
                    chk("sb_result", result, exp_q[0][31:0]);
                    chk("sb_tag", 32'(out_tag), 32'(exp_q[0][36:32]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back({tag, ref_model(op, x1, x2)});
        end
    end

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t, input logic [31:0] e);
        in_valid = 1'b1; op = o; x1 = a; x2 = b; tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_valid"}, 32'(out_valid), 32'h1);
        chk(nm, result, e);
        chk({nm, "_tag"}, 32'(out_tag), 32'(t));
    endtask

    initial begin
        int i, cyc;
        logic acc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_out_tag", 32'(out_tag), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;

        run_op("flt_1_2",    3'd1, 32'h3F800000, 32'h40000000, 5'd1, 32'h1);
        run_op("flt_m1_m2",  3'd1, 32'hBF800000, 32'hC0000000, 5'd2, 32'h0);
        run_op("fle_2_2",    3'd2, 32'h40000000, 32'h40000000, 5'd3, 32'h1);
        run_op("feq_zeros",  3'd0, 32'h80000000, 32'h00000000, 5'd4, 32'h1);
        run_op("flt_zeros",  3'd1, 32'h80000000, 32'h00000000, 5'd5, 32'h0);
        run_op("fmin_pz_nz", 3'd3, 32'h00000000, 32'h80000000, 5'd6, 32'h80000000);
        run_op("fmax_nz_pz", 3'd4, 32'h80000000, 32'h00000000, 5'd7, 32'h00000000);
        run_op("feq_nan",    3'd0, 32'h7FC00000, 32'h7FC00000, 5'd8, 32'h0);
        run_op("flt_nan",    3'd1, 32'h7FC00000, 32'h40000000, 5'd9, 32'h0);
        run_op("fle_nan",    3'd2, 32'h7FC00000, 32'h7FC00000, 5'd10, 32'h0);
        run_op("fmin_nan",   3'd3, 32'h7FC00000, 32'h40400000, 5'd11, 32'h40400000);
        run_op("fmax_2nan",  3'd4, 32'h7F800001, 32'hFFC00000, 5'd12, 32'h7FC00000);
        run_op("fmax_m1_2",  3'd4, 32'hBF800000, 32'h40000000, 5'd13, 32'h40000000);
        run_op("reserved7",  3'd7, 32'h3F800000, 32'h40000000, 5'd14, 32'h0);

        // Backpressure: 8 ops, consumer stalled for the first 5 cycles
        out_ready = 1'b0;
        i = 0; cyc = 0;
        while (i < 8 && cyc < 200) begin
            in_valid = 1'b1; op = 3'($urandom_range(0, 7)); x1 = pick();
            x2 = ($urandom_range(0, 4) == 0) ? x1 : pick(); tag = 5'(i);
            do begin
                @(negedge clk);
                acc = in_ready;
                if (cyc == 2) chk("bp_in_ready_full", 32'(in_ready), 32'h0);
                @(posedge clk); #1;
                cyc++;
                if (cyc == 5) out_ready = 1'b1;
            end while (!acc && cyc < 200);
            if (acc) i++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 32'(i), 32'd8);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1 chk("bp_drained", 32'(exp_q.size()), 32'h0);

        // Reset with two operations in flight
        in_valid = 1'b1; op = 3'd1; x1 = 32'h3F800000; x2 = 32'h40000000; tag = 5'd20;
        @(posedge clk); #1;
        tag = 5'd21;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_no_stale", 32'(out_valid), 32'h0);
        end
        run_op("post_rst_flt", 3'd1, 32'h3F800000, 32'h40000000, 5'd22, 32'h1);
        @(posedge clk); #1;

        // Throughput: 100 random back-to-back operations
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_valid = 1'b1; op = 3'($urandom_range(0, 7)); x1 = pick();
            x2 = ($urandom_range(0, 4) == 0) ? x1 : pick(); tag = 5'(k);
            @(negedge clk);
            chk("tp_in_ready", 32'(in_ready), 32'h1);
            if (k >= 2) chk("tp_out_valid", 32'(out_valid), 32'h1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1 chk("tp_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
